// File: rtl/nmk_903_depacker.sv
// Rebuilds 8-bit A bytes from nibble pairs on the NMK-903 packed bus and queues them in a DEPTH-entry FIFO.
// Head is valid the edge the second half lands; IN_READY drops only in SECOND while full. Optional B check: NMK903_BCHECK_EN.
module nmk_903_depacker #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [7:0]               IN_BYTE,
    input  logic                     ANIBSEL,
    input  logic                     SYNC,
    output logic                     A_VALID,
    input  logic                     A_READY,
    output logic [7:0]               A_BYTE,
    output logic [3:0]               B_NIB,
    output logic                     ALLF,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     B_ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef enum logic {ST_FIRST, ST_SECOND} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_held_a;
    logic           r_order;
    logic [12:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_level;

    logic           w_accept;
    logic           w_load;
    logic           w_push;
    logic           w_pop;
    logic [7:0]     w_word_a;
    logic [12:0]    w_head;

    assign IN_READY = (r_state == ST_FIRST) || (r_level != L_FULL);
    assign w_accept = IN_VALID && IN_READY;
    assign A_VALID  = (r_level != '0);
    assign w_pop    = A_VALID && A_READY;
    assign w_word_a = r_order ? {IN_BYTE[3:0], r_held_a} : {r_held_a, IN_BYTE[3:0]};
    assign w_head   = r_mem[r_rptr];

    // SYNC takes precedence: a byte accepted alongside it opens a fresh pair.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_push      = 1'b0;
        if (SYNC) begin
            w_state_nxt = w_accept ? ST_SECOND : ST_FIRST;
            w_load      = w_accept;
        end else if (w_accept) begin
            if (r_state == ST_FIRST) begin
                w_state_nxt = ST_SECOND;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = ST_FIRST;
                w_push      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_FIRST;
            r_held_a <= 4'h0;
            r_order  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_held_a <= IN_BYTE[3:0];
                r_order  <= ANIBSEL;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while empty.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= {(w_word_a[3:0] == 4'hF), IN_BYTE[7:4], w_word_a};
    end

    assign A_BYTE = A_VALID ? w_head[7:0]  : 8'h00;
    assign B_NIB  = A_VALID ? w_head[11:8] : 4'h0;
    assign ALLF   = A_VALID ? w_head[12]   : 1'b0;
    assign LEVEL  = r_level;

`ifdef NMK903_BCHECK_EN
    logic [3:0] r_held_b;
    logic       r_b_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_held_b <= 4'h0;
            r_b_err  <= 1'b0;
        end else begin
            if (w_load) r_held_b <= IN_BYTE[7:4];
            if (w_push && (IN_BYTE[7:4] != r_held_b)) r_b_err <= 1'b1;
        end
    end

    assign B_ERR = r_b_err;
`else
    assign B_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_nmk_903_depacker.sv
// Directed bench for nmk_903_depacker: hand-computed words, backpressure, SYNC and async reset.
module tb_nmk_903_depacker;
    localparam int DEPTH = 4;
`ifdef NMK903_BCHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] IN_BYTE = 8'h00;
    logic       ANIBSEL = 1'b0;
    logic       SYNC = 1'b0;
    logic       A_VALID;
    logic       A_READY = 1'b0;
    logic [7:0] A_BYTE;
    logic [3:0] B_NIB;
    logic       ALLF;
    logic [2:0] LEVEL;
    logic       B_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    nmk_903_depacker #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_BYTE(IN_BYTE), .ANIBSEL(ANIBSEL), .SYNC(SYNC), .A_VALID(A_VALID),
        .A_READY(A_READY), .A_BYTE(A_BYTE), .B_NIB(B_NIB), .ALLF(ALLF),
        .LEVEL(LEVEL), .B_ERR(B_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer a byte at the falling edge; hold it until accepted or the budget runs out.
    task automatic send(input logic [7:0] b, input logic sel, input logic sy);
        bit done = 1'b0;
        @(negedge CLK);
        IN_VALID = 1'b1; IN_BYTE = b; ANIBSEL = sel; SYNC = sy;
        for (int i = 0; i < 20 && !done; i++) begin
            if (IN_READY) begin
                @(posedge CLK);
                done = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        #1;
        IN_VALID = 1'b0; SYNC = 1'b0;
    endtask

    task automatic pop();
        @(negedge CLK);
        A_READY = 1'b1;
        @(posedge CLK);
        #1;
        A_READY = 1'b0;
    endtask

    task automatic head(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic f, input logic [2:0] lvl);
        @(negedge CLK);
        chk({tag, "_vld"},   32'(A_VALID), 32'd1);
        chk({tag, "_a"},     32'(A_BYTE),  32'(a));
        chk({tag, "_b"},     32'(B_NIB),   32'(b));
        chk({tag, "_allf"},  32'(ALLF),    32'(f));
        chk({tag, "_level"}, 32'(LEVEL),   32'(lvl));
    endtask

    initial begin
        logic [7:0] exp_a [5];
        logic [3:0] exp_b [5];

        #12;
        chk("rst_vld",   32'(A_VALID),  32'd0);
        chk("rst_level", 32'(LEVEL),    32'd0);
        chk("rst_a",     32'(A_BYTE),   32'd0);
        chk("rst_rdy",   32'(IN_READY), 32'd1);
        chk("rst_berr",  32'(B_ERR),    32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // 1: low nibble first
        send(8'h35, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t1_half_vld", 32'(A_VALID), 32'd0);
        send(8'h3A, 1'b1, 1'b0);
        chk("t1_latency", 32'(A_VALID), 32'd1);
        head("t1", 8'hA5, 4'h3, 1'b0, 3'd1);
        pop();
        @(negedge CLK);
        chk("t1_empty_level", 32'(LEVEL), 32'd0);
        chk("t1_empty_a", 32'(A_BYTE), 32'd0);

        // 2: high nibble first, ANIBSEL flip on second half ignored
        send(8'h2C, 1'b0, 1'b0);
        send(8'h2F, 1'b1, 1'b0);
        head("t2", 8'hCF, 4'h2, 1'b1, 3'd1);
        pop();

        // 3: fill, stall second half, pop, then drain in order
        for (int i = 0; i < 5; i++) begin
            exp_a[i] = {4'(i + 1), 4'(i)};
            exp_b[i] = 4'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            send({4'(i), 4'(i)}, 1'b1, 1'b0);
            send({4'(i), 4'(i + 1)}, 1'b1, 1'b0);
        end
        @(negedge CLK);
        chk("t3_full_level", 32'(LEVEL), 32'(DEPTH));
        chk("t3_first_rdy", 32'(IN_READY), 32'd1);
        send(8'h44, 1'b1, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b1; IN_BYTE = 8'h45;
        chk("t3_stall_rdy", 32'(IN_READY), 32'd0);
        @(negedge CLK);
        chk("t3_stall_rdy2", 32'(IN_READY), 32'd0);
        chk("t3_stall_level", 32'(LEVEL), 32'(DEPTH));
        A_READY = 1'b1;
        @(posedge CLK);
        #1;
        A_READY = 1'b0;
        @(negedge CLK);
        chk("t3_after_pop_level", 32'(LEVEL), 32'(DEPTH - 1));
        chk("t3_after_pop_rdy", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        for (int i = 1; i < 5; i++) begin
            head($sformatf("t3_w%0d", i), exp_a[i], exp_b[i], 1'b0, 3'(5 - i));
            pop();
        end
        @(negedge CLK);
        chk("t3_drained", 32'(LEVEL), 32'd0);

        // 4: SYNC drops held 8'h11 and keeps 8'h24 as new first half
        send(8'h11, 1'b1, 1'b0);
        send(8'h24, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t4_no_word", 32'(LEVEL), 32'd0);
        send(8'h27, 1'b1, 1'b0);
        head("t4", 8'h74, 4'h2, 1'b0, 3'd1);
        pop();

        // 5: B mismatch is sticky when checking is built in
        send(8'h51, 1'b1, 1'b0);
        send(8'h62, 1'b1, 1'b0);
        head("t5", 8'h21, 4'h6, 1'b0, 3'd1);
        chk("t5_berr", 32'(B_ERR), 32'(BCHK));
        pop();
        send(8'h33, 1'b1, 1'b0);
        send(8'h34, 1'b1, 1'b0);
        head("t5b", 8'h43, 4'h3, 1'b0, 3'd1);
        chk("t5_berr_sticky", 32'(B_ERR), 32'(BCHK));
        pop();

        // 6: async reset with two words queued and a held half
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        send(8'h04, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t6_pre_level", 32'(LEVEL), 32'd2);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_rst_vld",   32'(A_VALID), 32'd0);
        chk("t6_rst_level", 32'(LEVEL),   32'd0);
        chk("t6_rst_a",     32'(A_BYTE),  32'd0);
        chk("t6_rst_berr",  32'(B_ERR),   32'd0);
        @(negedge CLK);
        RST = 1'b0;
        send(8'h35, 1'b1, 1'b0);
        send(8'h3A, 1'b1, 1'b0);
        head("t6_after", 8'hA5, 4'h3, 1'b0, 3'd1);
        chk("t6_after_berr", 32'(B_ERR), 32'd0);
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
